// File: rtl/gelato_register_bank_responder.sv
// rtl/gelato_register_bank_responder.sv - banked register storage answering one operand-collect request per round
// Optional GELATO_REG_BYPASS_EN: a same-register writeback collision forwards wb_data instead of blocking the bank.
module gelato_register_bank_responder #(
    parameter int BANK_NUM       = 4,
    parameter int COLLECTOR_SIZE = 4,
    parameter int REG_W          = 5,
    parameter int DATA_W         = 32,
    parameter int CIDX_W         = $clog2(COLLECTOR_SIZE)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rdy,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [COLLECTOR_SIZE-1:0]          req_entry_valid,
    input  logic [COLLECTOR_SIZE*CIDX_W-1:0]   req_collector_num,
    input  logic [COLLECTOR_SIZE*3*REG_W-1:0]  req_reg_num,
    input  logic [COLLECTOR_SIZE*3-1:0]        req_reg_valid,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [BANK_NUM-1:0]                resp_data_valid,
    output logic [BANK_NUM*CIDX_W-1:0]         resp_collector_index,
    output logic [BANK_NUM*2-1:0]              resp_reg_index,
    output logic [BANK_NUM*DATA_W-1:0]         resp_data,
    input  logic                               wb_valid,
    input  logic [REG_W-1:0]                   wb_reg,
    input  logic [DATA_W-1:0]                  wb_data
);
    localparam int BANK_W = $clog2(BANK_NUM);
    localparam int ROW_W  = REG_W - BANK_W;
    localparam int ROWS   = 1 << ROW_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [CIDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [REG_W-1:0]           op_reg_q [COLLECTOR_SIZE][3];
    logic [REG_W-1:0]           op_reg_d [COLLECTOR_SIZE][3];
    logic                       op_vld_q [COLLECTOR_SIZE][3];
    logic                       op_vld_d [COLLECTOR_SIZE][3];
    logic [CIDX_W-1:0]          cnum_q [COLLECTOR_SIZE];
    logic [CIDX_W-1:0]          cnum_d [COLLECTOR_SIZE];
    logic [BANK_NUM-1:0]        resp_dv_q, resp_dv_d;
    logic [BANK_NUM*CIDX_W-1:0] resp_cidx_q, resp_cidx_d;
    logic [BANK_NUM*2-1:0]      resp_ridx_q, resp_ridx_d;
    logic [BANK_NUM*DATA_W-1:0] resp_data_q, resp_data_d;
    logic [DATA_W-1:0]          mem_q [BANK_NUM][ROWS];

    logic [BANK_NUM-1:0]        win_found;
    logic [ROW_W-1:0]           win_row [BANK_NUM];
    logic [CIDX_W-1:0]          win_slot [BANK_NUM];
    logic [1:0]                 win_op [BANK_NUM];
    logic [CIDX_W-1:0]          scan_slot;
    logic [REG_W-1:0]           cand;

    logic                       wb_en;
    logic [BANK_NUM-1:0]        wb_hit, grant;
    logic [BANK_NUM-1:0]        lane_dv;
    logic [BANK_NUM*CIDX_W-1:0] lane_cidx;
    logic [BANK_NUM*2-1:0]      lane_ridx;
    logic [BANK_NUM*DATA_W-1:0] lane_data;

    assign req_ready            = (state_q == IDLE);
    assign resp_valid           = (state_q == RESP);
    assign resp_data_valid      = resp_dv_q;
    assign resp_collector_index = resp_cidx_q;
    assign resp_reg_index       = resp_ridx_q;
    assign resp_data            = resp_data_q;
    assign wb_en                = rdy && wb_valid && (wb_reg != '0);

    // Per-bank round-robin scan: slots from rr_ptr, operands 1..3 within a slot.
    always_comb begin
        scan_slot = '0;
        cand      = '0;
        win_found = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            win_row[b]  = '0;
            win_slot[b] = '0;
            win_op[b]   = '0;
            for (int k = 0; k < COLLECTOR_SIZE; k++) begin
                scan_slot = CIDX_W'((int'(rr_ptr_q) + k) % COLLECTOR_SIZE);
                for (int o = 0; o < 3; o++) begin
                    cand = op_reg_q[scan_slot][o];
                    if (!win_found[b] && op_vld_q[scan_slot][o] && (cand != '0)
                        && (cand[BANK_W-1:0] == BANK_W'(b))) begin
                        win_found[b] = 1'b1;
                        win_row[b]   = cand[REG_W-1:BANK_W];
                        win_slot[b]  = scan_slot;
                        win_op[b]    = 2'(o + 1);
                    end
                end
            end
        end
    end

    // A writeback to a bank steals its single port for this round.
    always_comb begin
        wb_hit    = '0;
        grant     = '0;
        lane_dv   = '0;
        lane_cidx = '0;
        lane_ridx = '0;
        lane_data = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            wb_hit[b] = wb_en && (wb_reg[BANK_W-1:0] == BANK_W'(b));
`ifdef GELATO_REG_BYPASS_EN
            grant[b] = win_found[b] && (!wb_hit[b] || (wb_reg == {win_row[b], BANK_W'(b)}));
`else
            grant[b] = win_found[b] && !wb_hit[b];
`endif
            if (grant[b]) begin
                lane_dv[b]                     = 1'b1;
                lane_cidx[b*CIDX_W +: CIDX_W]  = cnum_q[win_slot[b]];
                lane_ridx[b*2 +: 2]            = win_op[b];
                lane_data[b*DATA_W +: DATA_W]  = wb_hit[b] ? wb_data : mem_q[b][win_row[b]];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_reg_d    = op_reg_q;
        op_vld_d    = op_vld_q;
        cnum_d      = cnum_q;
        resp_dv_d   = resp_dv_q;
        resp_cidx_d = resp_cidx_q;
        resp_ridx_d = resp_ridx_q;
        resp_data_d = resp_data_q;
        if (rdy) begin
            case (state_q)
                IDLE: if (req_valid) begin
                    state_d = ARB;
                    for (int s = 0; s < COLLECTOR_SIZE; s++) begin
                        cnum_d[s] = req_collector_num[s*CIDX_W +: CIDX_W];
                        for (int o = 0; o < 3; o++) begin
                            op_reg_d[s][o] = req_reg_num[(s*3+o)*REG_W +: REG_W];
                            op_vld_d[s][o] = req_entry_valid[s] && req_reg_valid[s*3+o];
                        end
                    end
                end
                ARB: begin
                    state_d     = RESP;
                    rr_ptr_d    = CIDX_W'((int'(rr_ptr_q) + 1) % COLLECTOR_SIZE);
                    resp_dv_d   = lane_dv;
                    resp_cidx_d = lane_cidx;
                    resp_ridx_d = lane_ridx;
                    resp_data_d = lane_data;
                end
                RESP: if (resp_ready) begin
                    state_d     = IDLE;
                    resp_dv_d   = '0;
                    resp_cidx_d = '0;
                    resp_ridx_d = '0;
                    resp_data_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            resp_dv_q   <= '0;
            resp_cidx_q <= '0;
            resp_ridx_q <= '0;
            resp_data_q <= '0;
            for (int s = 0; s < COLLECTOR_SIZE; s++) begin
                cnum_q[s] <= '0;
                for (int o = 0; o < 3; o++) begin
                    op_reg_q[s][o] <= '0;
                    op_vld_q[s][o] <= 1'b0;
                end
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_dv_q   <= resp_dv_d;
            resp_cidx_q <= resp_cidx_d;
            resp_ridx_q <= resp_ridx_d;
            resp_data_q <= resp_data_d;
            op_reg_q    <= op_reg_d;
            op_vld_q    <= op_vld_d;
            cnum_q      <= cnum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_en) begin
            mem_q[wb_reg[BANK_W-1:0]][wb_reg[REG_W-1:BANK_W]] <= wb_data;
        end
    end

endmodule

// File: tb/tb_gelato_register_bank_responder.sv
// tb/tb_gelato_register_bank_responder.sv - directed vector bench for gelato_register_bank_responder
module tb_gelato_register_bank_responder;

    typedef struct {
        logic [3:0]   ev;
        logic [7:0]   cn;
        logic [59:0]  rn;
        logic [11:0]  rv;
        logic [3:0]   xv;
        logic [7:0]   xc;
        logic [7:0]   xi;
        logic [127:0] xd;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rdy = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_entry_valid = '0;
    logic [7:0]   req_collector_num = '0;
    logic [59:0]  req_reg_num = '0;
    logic [11:0]  req_reg_valid = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [3:0]   resp_data_valid;
    logic [7:0]   resp_collector_index;
    logic [7:0]   resp_reg_index;
    logic [127:0] resp_data;
    logic         wb_valid = 1'b0;
    logic [4:0]   wb_reg = '0;
    logic [31:0]  wb_data = '0;

    int   errors = 0;
    int   checks = 0;
    vec_t vt [12];

    gelato_register_bank_responder dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_entry_valid(req_entry_valid), .req_collector_num(req_collector_num),
        .req_reg_num(req_reg_num), .req_reg_valid(req_reg_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data_valid(resp_data_valid), .resp_collector_index(resp_collector_index),
        .resp_reg_index(resp_reg_index), .resp_data(resp_data),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic clr(input int n);
        vt[n].ev = '0; vt[n].cn = '0; vt[n].rn = '0; vt[n].rv = '0;
        vt[n].xv = '0; vt[n].xc = '0; vt[n].xi = '0; vt[n].xd = '0;
    endtask

    task automatic add_op(input int n, input int s, input int o, input logic [4:0] r, input logic [1:0] c);
        vt[n].rn[(s*3+o-1)*5 +: 5] = r;
        vt[n].rv[s*3+o-1]          = 1'b1;
        vt[n].ev[s]                = 1'b1;
        vt[n].cn[s*2 +: 2]         = c;
    endtask

    task automatic exp_lane(input int n, input int b, input logic [1:0] c, input logic [1:0] idx, input logic [31:0] d);
        vt[n].xv[b]         = 1'b1;
        vt[n].xc[b*2 +: 2]  = c;
        vt[n].xi[b*2 +: 2]  = idx;
        vt[n].xd[b*32 +: 32] = d;
    endtask

    // Presents the request for one accept edge, then scrambles the buses; leaves the DUT in ARB.
    task automatic accept(input int n, input string tag);
        req_valid         = 1'b1;
        req_entry_valid   = vt[n].ev;
        req_collector_num = vt[n].cn;
        req_reg_num       = vt[n].rn;
        req_reg_valid     = vt[n].rv;
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid         = 1'b0;
        req_entry_valid   = '1;
        req_collector_num = '1;
        req_reg_num       = '1;
        req_reg_valid     = '1;
        chk({tag, "_arb_no_resp"}, resp_valid, 1'b0);
    endtask

    task automatic check_resp(input int n, input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 1'b1);
        chk({tag, "_data_valid"}, resp_data_valid, vt[n].xv);
        chk({tag, "_cidx"}, resp_collector_index, vt[n].xc);
        chk({tag, "_reg_index"}, resp_reg_index, vt[n].xi);
        chk({tag, "_data"}, resp_data, vt[n].xd);
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_idle_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_idle_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_data_valid", resp_data_valid, 4'h0);
        chk("reset_data", resp_data, 128'h0);
        rst_n = 1'b1;
        tick();

        wb(5'd5, 32'hDEADBEEF);
        wb(5'd6, 32'h00000006);
        wb(5'd4, 32'h00000044);
        wb(5'd8, 32'h00000088);
        wb(5'd1, 32'h00000011);
        wb(5'd7, 32'h00000077);
        wb(5'd0, 32'h000000FF);

        for (int i = 0; i < 12; i++) clr(i);
        // v0 rr=0: two banks served from one slot
        add_op(0, 0, 1, 5'd5, 2'd0); add_op(0, 0, 2, 5'd6, 2'd0);
        exp_lane(0, 1, 2'd0, 2'd1, 32'hDEADBEEF); exp_lane(0, 2, 2'd0, 2'd2, 32'h6);
        // v1 rr=1 / v2 rr=2: bank0 conflict between slot0 and slot1
        add_op(1, 0, 1, 5'd4, 2'd2); add_op(1, 1, 1, 5'd8, 2'd3);
        exp_lane(1, 0, 2'd3, 2'd1, 32'h88);
        add_op(2, 0, 1, 5'd4, 2'd2); add_op(2, 1, 1, 5'd8, 2'd3);
        exp_lane(2, 0, 2'd2, 2'd1, 32'h44);
        // v3 rr=3: scan starts at slot3 and wraps to slot0
        add_op(3, 0, 1, 5'd7, 2'd2); add_op(3, 0, 3, 5'd4, 2'd2); add_op(3, 3, 2, 5'd8, 2'd1);
        exp_lane(3, 0, 2'd1, 2'd2, 32'h88); exp_lane(3, 3, 2'd2, 2'd1, 32'h77);
        // v4..v6: r0, no reg_valid, no entry_valid -> empty responses
        add_op(4, 0, 1, 5'd0, 2'd1);
        vt[5].ev = 4'hF; vt[5].rn[4:0] = 5'd5; vt[5].rn[9:5] = 5'd6;
        add_op(6, 2, 1, 5'd5, 2'd1); add_op(6, 2, 2, 5'd6, 2'd1); vt[6].ev = 4'h0;
        // v7 rr=3: operand order within one slot
        add_op(7, 3, 1, 5'd8, 2'd3); add_op(7, 3, 2, 5'd1, 2'd3); add_op(7, 3, 3, 5'd4, 2'd3);
        exp_lane(7, 0, 2'd3, 2'd1, 32'h88); exp_lane(7, 1, 2'd3, 2'd2, 32'h11);
        // v8: single r5 read in slot0; v9: r5 in slot1 cnum1; v10: r6 in slot0
        add_op(8, 0, 1, 5'd5, 2'd0); exp_lane(8, 1, 2'd0, 2'd1, 32'hDEADBEEF);
        add_op(9, 1, 1, 5'd5, 2'd1);
        add_op(10, 0, 1, 5'd6, 2'd0); exp_lane(10, 2, 2'd0, 2'd1, 32'h6);

        for (int i = 0; i < 8; i++) begin
            accept(i, $sformatf("vec%0d", i));
            tick();
            check_resp(i, $sformatf("vec%0d", i));
            release_resp($sformatf("vec%0d", i));
        end

        // Backpressure with a write to the held register during RESP
        accept(8, "bp");
        tick();
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1;
        for (int c = 0; c < 3; c++) begin
            tick();
            wb_valid = 1'b0;
            check_resp(8, $sformatf("bp_hold%0d", c));
            chk($sformatf("bp_req_ready%0d", c), req_ready, 1'b0);
        end
        release_resp("bp");

        // Writeback to the same register in the ARB cycle
        accept(9, "coll");
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
        tick();
        wb_valid = 1'b0;
`ifdef GELATO_REG_BYPASS_EN
        exp_lane(9, 1, 2'd1, 2'd1, 32'h1234);
`endif
        check_resp(9, "coll");
        release_resp("coll");

        clr(11); add_op(11, 1, 1, 5'd5, 2'd1); exp_lane(11, 1, 2'd1, 2'd1, 32'h1234);
        accept(11, "coll_rb");
        tick();
        check_resp(11, "coll_rb");
        release_resp("coll_rb");

        // Writeback to a different register in the same bank blocks both builds
        clr(9); add_op(9, 1, 1, 5'd5, 2'd1);
        accept(9, "coll_diff");
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h22;
        tick();
        wb_valid = 1'b0;
        check_resp(9, "coll_diff");
        release_resp("coll_diff");

        // rdy low freezes the FSM and blocks writes
        rdy = 1'b0;
        req_valid = 1'b1; req_entry_valid = 4'h1; req_reg_num = 60'd5; req_reg_valid = 12'h1;
        wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'hBAD;
        tick();
        tick();
        chk("frz_req_ready", req_ready, 1'b1);
        chk("frz_resp_valid", resp_valid, 1'b0);
        req_valid = 1'b0; wb_valid = 1'b0; rdy = 1'b1;
        accept(10, "frz_rb");
        tick();
        check_resp(10, "frz_rb");
        release_resp("frz_rb");

        // Asynchronous reset while a response is held
        accept(8, "rst");
        tick();
        chk("rst_pre_valid", resp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_data_valid", resp_data_valid, 4'h0);
        chk("rst_data", resp_data, 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        accept(2, "rst_rr");
        tick();
        check_resp(2, "rst_rr");
        release_resp("rst_rr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
